// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR address sequencer.
package fir_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fir_state_t;

  function automatic bit taps_ok(input int taps);
    return (taps >= 2) && (taps <= 256);
  endfunction

endpackage

// File: rtl/fir_addr_gen_circ_ptr.sv
// Modulo-MOD circular pointer that steps by +1 or -1, with a synchronous load.
module circ_ptr
  import fir_pkg::*;
#(
  parameter int MOD = 16,
  parameter int DIR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MOD - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // A 256-entry ring wraps for free on 8-bit overflow; smaller rings need the compare.
  generate
    if (MOD == 256) begin : g_nat
      always_comb ptr_d = (DIR > 0) ? ptr_q + 1'b1 : ptr_q - 1'b1;
    end else begin : g_cmp
      always_comb begin
        ptr_d = ptr_q;
        if (DIR > 0) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        else         ptr_d = (ptr_q == '0) ? LAST : ptr_q - 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr_q <= '0;
    else if (load) ptr_q <= load_val;
    else if (step) ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fir_addr_gen.sv
// FIR address sequencer: writes each accepted sample, walks all taps with paired
// sample/coefficient addresses, waits for the pipeline to drain, then hands off.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int PIPE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] smp_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  generate
    if (!taps_ok(TAPS)) begin : g_bad_taps
      $error("fir_addr_gen: TAPS out of range 2..256");
    end
    if (PIPE < 1 || PIPE > 15) begin : g_bad_pipe
      $error("fir_addr_gen: PIPE out of range 1..15");
    end
  endgenerate

  fir_state_t        state_q;
  logic [ADDR_W-1:0] k_q;
  logic [3:0]        d_q;
  logic [ADDR_W-1:0] wp, rp;
  logic              wr_en_q, mac_en_q, mac_first_q, out_valid_q;
  logic [ADDR_W-1:0] wr_addr_q, smp_addr_q, coef_addr_q;
  logic              accept, issue, handshake;

  assign accept    = (state_q == IDLE) && in_valid;
  // Tap addresses are issued on the edge leaving WRITE and on every MAC edge but the last.
  assign issue     = (state_q == WRITE) || ((state_q == MAC) && (coef_addr_q != LAST));
  assign handshake = (state_q == DONE) && out_ready;

  circ_ptr #(.MOD(TAPS), .DIR(1)) u_wp (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0), .step(handshake), .ptr(wp)
  );

  circ_ptr #(.MOD(TAPS), .DIR(-1)) u_rp (
    .clk(clk), .rst(rst), .load(accept), .load_val(wp), .step(issue), .ptr(rp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      d_q         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      smp_addr_q  <= '0;
      coef_addr_q <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (issue) begin
        smp_addr_q  <= rp;
        coef_addr_q <= k_q;
        mac_en_q    <= 1'b1;
        mac_first_q <= (k_q == '0);
        k_q         <= k_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= wp;
            k_q       <= '0;
          end
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          state_q <= MAC;
        end
        MAC: begin
          if (coef_addr_q == LAST) begin
            state_q     <= DRAIN;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            d_q         <= 4'(PIPE);
          end
        end
        DRAIN: begin
          d_q <= d_q - 1'b1;
          if (d_q == 4'd1) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign smp_addr  = smp_addr_q;
  assign coef_addr = coef_addr_q;
  assign mac_en    = mac_en_q;
  assign mac_first = mac_first_q;
  assign out_valid = out_valid_q;

endmodule
